// File: rtl/bg_port_arbiter.sv
// bg_port_arbiter
//   Two-port arbiter and sequencer for one 8-bank SRAM group. Each SRAM is
//   single-port with active-low chip/write enables and a 1-cycle read latency.
//   Every cycle, each bank is granted to at most one port. When both ports want
//   the same bank, a per-bank round-robin bit decides. Reads return on the
//   granting port one cycle after the grant.
//
// Ports
//   clk, rst             clock; asynchronous active-high reset
//   a_* / b_*            requester ports: valid/ready handshake, we, bank,
//                        addr, wdata; rvalid/rdata read response (no stall)
//   bg_en, bg_wen        per-bank CEB / WEB, active-low
//   bg_addr, bg_din      per-bank address / write data, bank i at [i*W +: W]
//   bg_dout              per-bank SRAM Q
//   conflict_cnt         saturating count of same-bank collision cycles
module bg_port_arbiter #(
  parameter int NB = 8,
  parameter int AW = 7,
  parameter int DW = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic              a_we,
  input  logic [2:0]        a_bank,
  input  logic [AW-1:0]     a_addr,
  input  logic [DW-1:0]     a_wdata,
  output logic              a_rvalid,
  output logic [DW-1:0]     a_rdata,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic              b_we,
  input  logic [2:0]        b_bank,
  input  logic [AW-1:0]     b_addr,
  input  logic [DW-1:0]     b_wdata,
  output logic              b_rvalid,
  output logic [DW-1:0]     b_rdata,
  output logic [NB-1:0]     bg_en,
  output logic [NB-1:0]     bg_wen,
  output logic [NB*AW-1:0]  bg_addr,
  output logic [NB*DW-1:0]  bg_din,
  input  logic [NB*DW-1:0]  bg_dout,
  output logic [15:0]       conflict_cnt
);

  localparam int BW = 3;

  // Round-robin priority per bank: 0 prefers A, 1 prefers B.
  logic [NB-1:0] prio_q, prio_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          a_rd_v_q, a_rd_v_d;
  logic          b_rd_v_q, b_rd_v_d;
  logic [BW-1:0] a_rd_bank_q, a_rd_bank_d;
  logic [BW-1:0] b_rd_bank_q, b_rd_bank_d;

  logic          collide_s;
  logic          a_gnt_s, b_gnt_s;
  logic [NB-1:0]    en_s, wen_s;
  logic [NB*AW-1:0] addr_s;
  logic [NB*DW-1:0] din_s;

  // Grant decision; reset suppresses every grant combinationally.
  always_comb begin
    collide_s = a_valid & b_valid & (a_bank == b_bank);
    a_gnt_s   = 1'b0;
    b_gnt_s   = 1'b0;
    if (rst) begin
      a_gnt_s = 1'b0;
      b_gnt_s = 1'b0;
    end else begin
      a_gnt_s = a_valid & (~collide_s | ~prio_q[a_bank]);
      b_gnt_s = b_valid & (~collide_s |  prio_q[b_bank]);
    end
  end

  // Per-bank SRAM drive and priority next-state.
  always_comb begin
    en_s   = '1;
    wen_s  = '1;
    addr_s = '0;
    din_s  = '0;
    prio_d = prio_q;
    for (int k = 0; k < NB; k++) begin
      if (a_gnt_s && (a_bank == BW'(k))) begin
        en_s[k]            = 1'b0;
        wen_s[k]           = ~a_we;
        addr_s[k*AW +: AW] = a_addr;
        din_s[k*DW +: DW]  = a_wdata;
        prio_d[k]          = 1'b1;
      end else if (b_gnt_s && (b_bank == BW'(k))) begin
        en_s[k]            = 1'b0;
        wen_s[k]           = ~b_we;
        addr_s[k*AW +: AW] = b_addr;
        din_s[k*DW +: DW]  = b_wdata;
        prio_d[k]          = 1'b0;
      end else begin
        en_s[k]            = 1'b1;
        wen_s[k]           = 1'b1;
        addr_s[k*AW +: AW] = '0;
        din_s[k*DW +: DW]  = '0;
      end
    end
  end

  // Read-pending and collision-counter next-state.
  always_comb begin
    a_rd_v_d    = a_gnt_s & ~a_we;
    b_rd_v_d    = b_gnt_s & ~b_we;
    a_rd_bank_d = a_rd_bank_q;
    b_rd_bank_d = b_rd_bank_q;
    if (a_gnt_s) begin
      a_rd_bank_d = a_bank;
    end else begin
      a_rd_bank_d = a_rd_bank_q;
    end
    if (b_gnt_s) begin
      b_rd_bank_d = b_bank;
    end else begin
      b_rd_bank_d = b_rd_bank_q;
    end
    if (collide_s && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers; reset drops any in-flight read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_q      <= '0;
      cnt_q       <= 16'd0;
      a_rd_v_q    <= 1'b0;
      b_rd_v_q    <= 1'b0;
      a_rd_bank_q <= 3'd0;
      b_rd_bank_q <= 3'd0;
    end else begin
      prio_q      <= prio_d;
      cnt_q       <= cnt_d;
      a_rd_v_q    <= a_rd_v_d;
      b_rd_v_q    <= b_rd_v_d;
      a_rd_bank_q <= a_rd_bank_d;
      b_rd_bank_q <= b_rd_bank_d;
    end
  end

  assign a_ready      = a_gnt_s;
  assign b_ready      = b_gnt_s;
  assign bg_en        = en_s;
  assign bg_wen       = wen_s;
  assign bg_addr      = addr_s;
  assign bg_din       = din_s;
  assign conflict_cnt = cnt_q;
  assign a_rvalid     = a_rd_v_q;
  assign b_rvalid     = b_rd_v_q;

  // Read data comes straight from the SRAM Q of the bank read last cycle.
  assign a_rdata = a_rd_v_q ? bg_dout[a_rd_bank_q*DW +: DW] : '0;
  assign b_rdata = b_rd_v_q ? bg_dout[b_rd_bank_q*DW +: DW] : '0;

endmodule

// File: tb/tb_bg_port_arbiter.sv
// tb_bg_port_arbiter
//   Table-driven bench for bg_port_arbiter with a behavioural 8-bank SRAM
//   group, a shadow memory for expected read data and per-port response
//   queues.
module tb_bg_port_arbiter;
  localparam int NB = 8;
  localparam int AW = 7;
  localparam int DW = 256;

  logic              clk, rst;
  logic              a_valid, a_ready, a_we, a_rvalid;
  logic [2:0]        a_bank;
  logic [AW-1:0]     a_addr;
  logic [DW-1:0]     a_wdata, a_rdata;
  logic              b_valid, b_ready, b_we, b_rvalid;
  logic [2:0]        b_bank;
  logic [AW-1:0]     b_addr;
  logic [DW-1:0]     b_wdata, b_rdata;
  logic [NB-1:0]     bg_en, bg_wen;
  logic [NB*AW-1:0]  bg_addr;
  logic [NB*DW-1:0]  bg_din, bg_dout;
  logic [15:0]       conflict_cnt;

  bg_port_arbiter #(.NB(NB), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_bank(a_bank),
    .a_addr(a_addr), .a_wdata(a_wdata), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_bank(b_bank),
    .b_addr(b_addr), .b_wdata(b_wdata), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .bg_en(bg_en), .bg_wen(bg_wen), .bg_addr(bg_addr), .bg_din(bg_din),
    .bg_dout(bg_dout), .conflict_cnt(conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAM group: 1-cycle read latency, Q holds when not read.
  logic [DW-1:0] mem [NB][128];
  always @(posedge clk) begin
    for (int k = 0; k < NB; k++) begin
      if (!bg_en[k]) begin
        if (!bg_wen[k]) mem[k][bg_addr[k*AW +: AW]] <= bg_din[k*DW +: DW];
        else bg_dout[k*DW +: DW] <= mem[k][bg_addr[k*AW +: AW]];
      end
    end
  end

  typedef struct {
    logic av, awe; logic [2:0] ab; logic [6:0] aa; logic [7:0] ad;
    logic bv, bwe; logic [2:0] bb; logic [6:0] ba; logic [7:0] bd;
    logic era, erb; logic [7:0] een, ewen;
  } vec_t;

  vec_t vt [13];
  vec_t vrd0, vc4, vidle;
  logic [DW-1:0] shadow [NB][128];
  logic [DW-1:0] a_q [$];
  logic [DW-1:0] b_q [$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Compare the response of the previous cycle against the scoreboard.
  task automatic check_resp();
    logic [DW-1:0] e;
    chk("a_rvalid", DW'(a_rvalid), DW'(a_q.size() > 0));
    if (a_q.size() > 0) begin
      e = a_q.pop_front();
      chk("a_rdata", a_rdata, e);
    end else chk("a_rdata_idle", a_rdata, '0);
    chk("b_rvalid", DW'(b_rvalid), DW'(b_q.size() > 0));
    if (b_q.size() > 0) begin
      e = b_q.pop_front();
      chk("b_rdata", b_rdata, e);
    end else chk("b_rdata_idle", b_rdata, '0);
  endtask

  task automatic do_cycle(input vec_t v);
    logic [DW-1:0] ad, bd;
    @(negedge clk);
    check_resp();
    ad = {32{v.ad}};
    bd = {32{v.bd}};
    a_valid = v.av; a_we = v.awe; a_bank = v.ab; a_addr = v.aa; a_wdata = ad;
    b_valid = v.bv; b_we = v.bwe; b_bank = v.bb; b_addr = v.ba; b_wdata = bd;
    #1;
    chk("a_ready", DW'(a_ready), DW'(v.era));
    chk("b_ready", DW'(b_ready), DW'(v.erb));
    chk("bg_en", DW'(bg_en), DW'(v.een));
    chk("bg_wen", DW'(bg_wen), DW'(v.ewen));
    if (v.era) begin
      chk("a_bg_addr", DW'(bg_addr[v.ab*AW +: AW]), DW'(v.aa));
      if (v.awe) begin
        chk("a_bg_din", bg_din[v.ab*DW +: DW], ad);
        shadow[v.ab][v.aa] = ad;
      end else a_q.push_back(shadow[v.ab][v.aa]);
    end
    if (v.erb) begin
      chk("b_bg_addr", DW'(bg_addr[v.bb*AW +: AW]), DW'(v.ba));
      if (v.bwe) begin
        chk("b_bg_din", bg_din[v.bb*DW +: DW], bd);
        shadow[v.bb][v.ba] = bd;
      end else b_q.push_back(shadow[v.bb][v.ba]);
    end
  endtask

  initial begin
    //        A: v we bk addr data      B: v we bk addr data     rdyA rdyB en wen
    vt[0]  = '{1'b1,1'b1,3'd2,7'd5,8'hAA, 1'b1,1'b1,3'd6,7'd5,8'h55, 1'b1,1'b1,8'hBB,8'hBB};
    vt[1]  = '{1'b1,1'b0,3'd2,7'd5,8'h00, 1'b1,1'b0,3'd6,7'd5,8'h00, 1'b1,1'b1,8'hBB,8'hFF};
    vt[2]  = '{1'b1,1'b1,3'd3,7'd1,8'h11, 1'b0,1'b0,3'd0,7'd0,8'h00, 1'b1,1'b0,8'hF7,8'hF7};
    vt[3]  = '{1'b0,1'b0,3'd0,7'd0,8'h00, 1'b1,1'b1,3'd3,7'd2,8'h22, 1'b0,1'b1,8'hF7,8'hF7};
    vt[4]  = '{1'b1,1'b0,3'd3,7'd1,8'h00, 1'b1,1'b0,3'd3,7'd2,8'h00, 1'b1,1'b0,8'hF7,8'hFF};
    vt[5]  = '{1'b1,1'b0,3'd3,7'd1,8'h00, 1'b1,1'b0,3'd3,7'd2,8'h00, 1'b0,1'b1,8'hF7,8'hFF};
    vt[6]  = '{1'b1,1'b0,3'd3,7'd1,8'h00, 1'b1,1'b0,3'd3,7'd2,8'h00, 1'b1,1'b0,8'hF7,8'hFF};
    vt[7]  = '{1'b1,1'b0,3'd3,7'd1,8'h00, 1'b1,1'b0,3'd3,7'd2,8'h00, 1'b0,1'b1,8'hF7,8'hFF};
    vt[8]  = '{1'b1,1'b1,3'd1,7'd0,8'h33, 1'b0,1'b0,3'd0,7'd0,8'h00, 1'b1,1'b0,8'hFD,8'hFD};
    vt[9]  = '{1'b1,1'b0,3'd1,7'd0,8'h00, 1'b1,1'b0,3'd1,7'd0,8'h00, 1'b0,1'b1,8'hFD,8'hFF};
    vt[10] = '{1'b1,1'b1,3'd4,7'd7,8'h44, 1'b1,1'b1,3'd4,7'd8,8'h66, 1'b1,1'b0,8'hEF,8'hEF};
    vt[11] = '{1'b1,1'b0,3'd4,7'd7,8'h00, 1'b1,1'b0,3'd6,7'd5,8'h00, 1'b1,1'b1,8'hAF,8'hFF};
    vt[12] = '{1'b0,1'b0,3'd0,7'd0,8'h00, 1'b0,1'b0,3'd0,7'd0,8'h00, 1'b0,1'b0,8'hFF,8'hFF};
    vrd0   = '{1'b1,1'b0,3'd0,7'd0,8'h00, 1'b0,1'b0,3'd0,7'd0,8'h00, 1'b1,1'b0,8'hFE,8'hFF};
    vc4    = '{1'b1,1'b1,3'd4,7'd9,8'h77, 1'b1,1'b1,3'd4,7'd10,8'h88, 1'b1,1'b0,8'hEF,8'hEF};
    vidle  = vt[12];

    // Reset with both ports requesting the same bank.
    rst = 1'b1;
    a_valid = 1'b1; a_we = 1'b0; a_bank = 3'd0; a_addr = 7'd0; a_wdata = '0;
    b_valid = 1'b1; b_we = 1'b0; b_bank = 3'd0; b_addr = 7'd1; b_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_a_ready", DW'(a_ready), '0);
    chk("rst_b_ready", DW'(b_ready), '0);
    chk("rst_bg_en", DW'(bg_en), DW'(8'hFF));
    chk("rst_bg_wen", DW'(bg_wen), DW'(8'hFF));
    chk("rst_bg_addr", DW'(bg_addr), '0);
    chk("rst_cnt", DW'(conflict_cnt), '0);
    chk("rst_a_rvalid", DW'(a_rvalid), '0);
    chk("rst_b_rdata", b_rdata, '0);
    rst = 1'b0;
    a_valid = 1'b0;
    b_valid = 1'b0;

    for (int i = 0; i < 13; i++) begin
      do_cycle(vt[i]);
      if (i == 8) chk("cnt_after_collide", DW'(conflict_cnt), DW'(16'd4));
    end
    chk("cnt_after_table", DW'(conflict_cnt), DW'(16'd6));

    // Reset asserted while an A read of bank 0 is in flight.
    do_cycle(vrd0);
    rst = 1'b1;
    #1;
    chk("midrst_a_ready", DW'(a_ready), '0);
    chk("midrst_bg_en", DW'(bg_en), DW'(8'hFF));
    a_q.delete();
    @(negedge clk);
    chk("midrst_a_rvalid", DW'(a_rvalid), '0);
    rst = 1'b0;
    a_valid = 1'b0;
    b_valid = 1'b0;
    chk("midrst_cnt", DW'(conflict_cnt), '0);
    do_cycle(vc4);  // prio cleared: A wins bank 4 again

    // Counter saturation with continuous bank-5 write collisions.
    @(negedge clk);
    chk("sat_start", DW'(conflict_cnt), DW'(16'd1));
    a_valid = 1'b1; a_we = 1'b1; a_bank = 3'd5; a_addr = 7'd0;
    b_valid = 1'b1; b_we = 1'b1; b_bank = 3'd5; b_addr = 7'd1;
    repeat (65533) @(negedge clk);
    chk("sat_fffe", DW'(conflict_cnt), DW'(16'hFFFE));
    repeat (2) @(negedge clk);
    chk("sat_ffff", DW'(conflict_cnt), DW'(16'hFFFF));
    repeat (5) @(negedge clk);
    chk("sat_hold", DW'(conflict_cnt), DW'(16'hFFFF));
    a_valid = 1'b0;
    b_valid = 1'b0;
    do_cycle(vidle);
    do_cycle(vidle);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bg_port_arbiter.md
# bg_port_arbiter

Two-requester arbiter and sequencer for one 8-bank group (eight 128x256 single-port SRAMs, active-low chip and write enables, 1-cycle read latency). Two requester ports share the group, for example a butterfly-core read/write stream and a DMA load/store stream. Each cycle the block grants at most one access per bank, with per-bank round-robin priority. It drives the bank-group enable, write-enable, address and data lines and returns read data on the granting port. Requests to different banks proceed in parallel; same-bank requests are serialized.

## Interface
Parameters:
- NB, 8: number of banks in the group (bank index width 3).
- AW, 7: bank address width.
- DW, 256: data word width.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- a_valid / b_valid  in  1  request present on port A / B.
- a_ready / b_ready  out  1  request accepted this cycle; this is the grant.
- a_we / b_we  in  1  1 = write, 0 = read.
- a_bank / b_bank  in  3  target bank, 0..7.
- a_addr / b_addr  in  AW  word address in the bank.
- a_wdata / b_wdata  in  DW  write data.
- a_rvalid / b_rvalid  out  1  read data valid; the port cannot stall it.
- a_rdata / b_rdata  out  DW  read data.
- bg_en  out  NB  per-bank CEB, active-low.
- bg_wen  out  NB  per-bank WEB, active-low.
- bg_addr  out  NB*AW  per-bank address; bank i occupies bits [i*AW +: AW].
- bg_din  out  NB*DW  per-bank write data.
- bg_dout  in  NB*DW  per-bank SRAM Q.
- conflict_cnt  out  16  count of cycles with a same-bank collision; saturates at 0xFFFF.

## Operation
- Grant logic is combinational from the valids, banks and the prio register:
  - Different banks, or only one port valid: every valid port is granted.
  - Both valid on the same bank: the port selected by prio[bank] is granted and the other sees ready=0. prio[bank]=0 selects A, 1 selects B.
- prio update on a grant of bank k: prio[k] moves to the non-granted port (granted A sets prio[k]=1, granted B sets it to 0). Banks with no grant keep their prio bit.
- Drive for bank k when granted: bg_en[k]=0 and bg_wen[k]=~we, with bg_addr and bg_din taken from the winning port.
- Drive for a bank with no grant: bg_en=1, bg_wen=1, addr=0, din=0.
- Granted read: a pending register (rd_v, rd_bank) is loaded for that port. Next cycle rvalid=1 and rdata = bg_dout slice [rd_bank*DW +: DW], taken combinationally from the SRAM Q.
- Writes produce no response.
- A port may issue back-to-back reads; each is returned on the following cycle. The pending register is overwritten every cycle.
- conflict_cnt increments once per cycle in which a_valid & b_valid & (a_bank==b_bank), saturating at 0xFFFF.
- Requesters hold valid, we, bank, addr and wdata stable until ready. The block does not check this.

## Timing
- Grant is in the same cycle as the request: ready is combinational on valid.
- The SRAM samples at the end of the grant cycle N. rvalid/rdata appear in cycle N+1, giving a read latency of 1.
- Write then read of the same address, in consecutive granted cycles, returns the new data.
- Reset values:
  - a_ready, b_ready, a_rvalid, b_rvalid = 0.
  - bg_en, bg_wen = all 1.
  - bg_addr, bg_din, rdata = 0.
  - prio = 0 (A preferred everywhere).
  - conflict_cnt = 0.
- While rst is high, no grants are issued and bg_en stays all 1.
- Reset asserted mid-read clears rd_v asynchronously. The in-flight read is dropped and never returned.
- bank is 3 bits wide, so every value 0..7 is valid and there is no out-of-range case.

## Test plan
- Reset: assert rst with both ports valid -> ready=0, bg_en=0xFF, conflict_cnt=0. Release -> first grant on the next edge.
- Parallel access:
  - A writes bank 2 addr 5 = 0xAA..AA while B writes bank 6 addr 5 = 0x55..55 -> both ready, bg_en=0xBB.
  - A then reads bank 2 addr 5 while B reads bank 6 addr 5 -> next cycle a_rdata=0xAA..AA, b_rdata=0x55..55, both rvalid.
- Same-bank collision: both ports read bank 3 continuously for 4 cycles with A and B addresses distinct -> grants alternate A,B,A,B, each rvalid follows its grant by 1 cycle, conflict_cnt=4.
- Priority persistence:
  - A alone accesses bank 1 (prio[1]=1) -> then A and B collide on bank 1 -> B wins first.
  - Collide on bank 4 in the same cycle with no prior bank-4 history -> A wins.
- Reset mid-read: grant an A read of bank 0, assert rst before the next edge -> a_rvalid never asserts and prio returns to 0.
- Counter saturation: preload or force 65535 same-bank collision cycles -> conflict_cnt holds 0xFFFF, with no wrap to 0.
